// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an RV32IM bundle into ALU control/operands and
// issues it through a two-entry (main + skid) buffer with registered in_ready.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [31:0]     rs1_data,
  input  logic [31:0]     rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [5:0]      alu_ctrl,
  output logic [4:0]      rd,
  output logic            illegal
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [5:0]      ctrl;
    logic [4:0]      rd;
    logic            ill;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, dec;
  logic   in_ready_q, out_valid_q;
  logic   accept, drain, legal;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  always_comb begin
    dec      = '0;
    legal    = 1'b1;
    dec.rd   = instr[11:7];
    dec.a    = rs1_data;
    dec.b    = rs2_data;
    case (opcode)
      7'b0110011: begin
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000: dec.ctrl = 6'b000000;
              3'b001: begin dec.ctrl = 6'b000101; dec.b = {27'b0, rs2_data[4:0]}; end
              3'b010: dec.ctrl = 6'b000110;
              3'b011: dec.ctrl = 6'b000111;
              3'b100: dec.ctrl = 6'b000011;
              3'b101: begin dec.ctrl = 6'b000100; dec.b = {27'b0, rs2_data[4:0]}; end
              3'b110: dec.ctrl = 6'b000010;
              default: dec.ctrl = 6'b000001;
            endcase
          end
          7'b0100000: begin
            case (funct3)
              3'b000:  dec.ctrl = 6'b010001;
              3'b101:  begin dec.ctrl = 6'b010000; dec.b = {27'b0, rs2_data[4:0]}; end
              default: legal = 1'b0;
            endcase
          end
          7'b0000001: begin
            case (funct3)
              3'b000: dec.ctrl = 6'b001010;
              3'b001: dec.ctrl = 6'b001011;
              3'b010: dec.ctrl = 6'b001100;
              3'b011: dec.ctrl = 6'b001101;
              3'b100: dec.ctrl = 6'b001000;
              3'b101: dec.ctrl = 6'b001001;
              3'b110: dec.ctrl = 6'b001110;
              default: dec.ctrl = 6'b001111;
            endcase
          end
          default: legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec.b = {{20{instr[31]}}, instr[31:20]};
        case (funct3)
          3'b000: dec.ctrl = 6'b000000;
          3'b010: dec.ctrl = 6'b000110;
          3'b011: dec.ctrl = 6'b000111;
          3'b100: dec.ctrl = 6'b000011;
          3'b110: dec.ctrl = 6'b000010;
          3'b111: dec.ctrl = 6'b000001;
          3'b001: begin
            dec.b = {27'b0, instr[24:20]};
            if (funct7 == 7'b0000000) dec.ctrl = 6'b000101;
            else legal = 1'b0;
          end
          default: begin
            dec.b = {27'b0, instr[24:20]};
            if (funct7 == 7'b0000000)      dec.ctrl = 6'b000100;
            else if (funct7 == 7'b0100000) dec.ctrl = 6'b010000;
            else legal = 1'b0;
          end
        endcase
      end
      7'b0110111: begin
        dec.a    = '0;
        dec.b    = {instr[31:12], 12'b0};
        dec.ctrl = 6'b010111;
      end
      default: legal = 1'b0;
    endcase
    // Illegal beats carry only the flag so downstream sees a clean trap bundle.
    if (!legal) begin
      dec     = '0;
      dec.ill = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != S_FULL);
      out_valid_q <= (state_d != S_EMPTY);
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: if (accept) begin state_d = S_ONE; main_d = dec; end
      S_ONE: begin
        if (accept && drain)      main_d = dec;
        else if (accept)          begin state_d = S_FULL; skid_d = dec; end
        else if (drain)           state_d = S_EMPTY;
      end
      S_FULL: if (drain) begin state_d = S_ONE; main_d = skid_q; end
      default: state_d = S_EMPTY;
    endcase
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = '0;
    end
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    alu_a     = main_q.a;
    alu_b     = main_q.b;
    alu_ctrl  = main_q.ctrl;
    rd        = main_q.rd;
    illegal   = main_q.ill;
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a FIFO scoreboard of expected beats.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  ctrl;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] instr, rs1_data, rs2_data, alu_a, alu_b;
  logic [5:0]  alu_ctrl;
  logic [4:0]  rd;

  int   errors = 0;
  int   checks = 0;
  int   drains = 0;
  int   ncyc   = 0;
  exp_t q[$];
  exp_t pending;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid),
    .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .rd(rd),
    .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Handshakes are evaluated mid-cycle, then the edge is taken.
  task automatic cycle();
    exp_t e;
    bit acc, drn;
    @(negedge clk);
    acc = in_valid && in_ready && rst_n && !flush;
    drn = out_valid && out_ready && rst_n && !flush;
    if (drn) begin
      drains++;
      if (q.size() == 0) chk("spurious_out", {31'b0, out_valid}, 32'd0);
      else begin
        e = q.pop_front();
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        chk("alu_ctrl", {26'b0, alu_ctrl}, {26'b0, e.ctrl});
        chk("rd", {27'b0, rd}, {27'b0, e.rd});
        chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
      end
    end
    if (acc) q.push_back(pending);
    if (flush || !rst_n) q.delete();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] ea, input logic [31:0] eb, input logic [5:0] ec,
                      input logic [4:0] erd, input logic eill);
    bit got = 0;
    in_valid = 1'b1; instr = i; rs1_data = r1; rs2_data = r2;
    pending = '{a: ea, b: eb, ctrl: ec, rd: erd, ill: eill};
    for (int n = 0; n < 20 && !got; n++) begin
      got = in_ready;
      cycle();
    end
    if (!got) chk("send_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic drain_all();
    for (int n = 0; n < 20 && q.size() > 0; n++) cycle();
    chk("drain_empty", q.size(), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_ctrl"}, {26'b0, alu_ctrl}, 32'd0);
    chk({tag, "_rd"}, {27'b0, rd}, 32'd0);
    chk({tag, "_illegal"}, {31'b0, illegal}, 32'd0);
  endtask

  initial begin
    int c0, d0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; rs1_data = '0; rs2_data = '0; pending = '0;
    cycle(); cycle();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    cycle();

    // Single add bundle and latency
    send(32'h00208033, 32'd5, 32'd7, 32'd5, 32'd7, 6'b000000, 5'd0, 1'b0);
    in_valid = 1'b0;
    chk("latency_valid", {31'b0, out_valid}, 32'd1);
    drain_all();

    // Encoding sweep, streamed back to back
    send(32'h40208133, 32'd20, 32'd3, 32'd20, 32'd3, 6'b010001, 5'd2, 1'b0);
    send(32'h4020D133, 32'h80000000, 32'hFFFFFFE3, 32'h80000000, 32'd3, 6'b010000, 5'd2, 1'b0);
    send(32'h41F0D093, 32'h1234, 32'hDEAD, 32'h1234, 32'd31, 6'b010000, 5'd1, 1'b0);
    send(32'hFFF00093, 32'd9, 32'd1, 32'd9, 32'hFFFFFFFF, 6'b000000, 5'd1, 1'b0);
    send(32'h0220B1B3, 32'd11, 32'd13, 32'd11, 32'd13, 6'b001101, 5'd3, 1'b0);
    send(32'h123452B7, 32'hAAAA, 32'hBBBB, 32'd0, 32'h12345000, 6'b010111, 5'd5, 1'b0);
    send(32'h00209133, 32'd1, 32'h00000025, 32'd1, 32'd5, 6'b000101, 5'd2, 1'b0);
    send(32'hFFFFFFFF, 32'd4, 32'd6, 32'd0, 32'd0, 6'b000000, 5'd0, 1'b1);
    send(32'h40209133, 32'd4, 32'd6, 32'd0, 32'd0, 6'b000000, 5'd0, 1'b1);
    send(32'h0020F1B3, 32'hF0F0, 32'h0FF0, 32'hF0F0, 32'h0FF0, 6'b000001, 5'd3, 1'b0);
    in_valid = 1'b0;
    drain_all();

    // Backpressure: two accepts fill the buffer, then four beats in four cycles
    out_ready = 1'b0;
    send(32'h00208033, 32'd1, 32'd2, 32'd1, 32'd2, 6'b000000, 5'd0, 1'b0);
    send(32'h40208133, 32'd3, 32'd4, 32'd3, 32'd4, 6'b010001, 5'd2, 1'b0);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    cycle();
    chk("bp_stable_a", alu_a, 32'd1);
    c0 = ncyc; d0 = drains;
    out_ready = 1'b1;
    send(32'h0220B1B3, 32'd5, 32'd6, 32'd5, 32'd6, 6'b001101, 5'd3, 1'b0);
    send(32'h123452B7, 32'd0, 32'd0, 32'd0, 32'h12345000, 6'b010111, 5'd5, 1'b0);
    in_valid = 1'b0;
    drain_all();
    chk("bp_cycles", ncyc - c0, 32'd4);
    chk("bp_drains", drains - d0, 32'd4);

    // Flush while full with a bundle offered
    out_ready = 1'b0;
    send(32'h00208033, 32'd7, 32'd8, 32'd7, 32'd8, 6'b000000, 5'd0, 1'b0);
    send(32'h00208033, 32'd9, 32'd10, 32'd9, 32'd10, 6'b000000, 5'd0, 1'b0);
    in_valid = 1'b1; instr = 32'h40208133; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    d0 = drains;
    repeat (4) cycle();
    chk("flush_no_beats", drains - d0, 32'd0);

    // Reset mid-stream while full, then resume
    out_ready = 1'b0;
    send(32'h0020F1B3, 32'd1, 32'd1, 32'd1, 32'd1, 6'b000001, 5'd3, 1'b0);
    send(32'h0020F1B3, 32'd2, 32'd2, 32'd2, 32'd2, 6'b000001, 5'd3, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk_reset_vals("midreset");
    out_ready = 1'b1;
    send(32'hFFF00093, 32'd3, 32'd0, 32'd3, 32'hFFFFFFFF, 6'b000000, 5'd1, 1'b0);
    send(32'h41F0D093, 32'd4, 32'd0, 32'd4, 32'd31, 6'b010000, 5'd1, 1'b0);
    in_valid = 1'b0;
    drain_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered issue stage that sits directly upstream of the ALU. It accepts a decoded-operand bundle from the register-read stage: the raw instruction plus the rs1 and rs2 register values. It encodes the instruction into the ALU's 6-bit control code, selects and forms operands A and B, and presents them to the ALU/execute side through a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered `in_ready`.

## Interface
Parameters:
- `XLEN`, 32, operand width. Only 32 is supported.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `flush`  in  1  discard all buffered entries (pipeline redirect).
- `in_valid`  in  1  upstream bundle valid.
- `in_ready`  out  1  stage can accept a bundle. Registered.
- `instr`  in  32  RV32IM instruction word.
- `rs1_data`  in  32  register value for rs1.
- `rs2_data`  in  32  register value for rs2.
- `out_valid`  out  1  ALU bundle valid.
- `out_ready`  in  1  execute side accepts the bundle.
- `alu_a`  out  32  operand A (ALU rs1 input).
- `alu_b`  out  32  operand B (ALU rs2 input).
- `alu_ctrl`  out  6  ALU control code.
- `rd`  out  5  destination register, `instr[11:7]`.
- `illegal`  out  1  instruction not decodable by this stage.

## Operation
- The bundle is decoded combinationally on entry and stored already encoded. Each entry holds `alu_a`, `alu_b`, `alu_ctrl`, `rd` and `illegal`.
- OP (opcode 0110011), A = `rs1_data`:
  - funct7 0000000, B = `rs2_data`, by funct3:
    - 000 add → 000000
    - 001 sll → 000101
    - 010 slt → 000110
    - 011 sltu → 000111
    - 100 xor → 000011
    - 101 srl → 000100
    - 110 or → 000010
    - 111 and → 000001
  - For sll and srl, B = {27'b0, `rs2_data[4:0]`}.
  - funct7 0100000:
    - funct3 000 sub → 010001
    - funct3 101 sra → 010000, B = {27'b0, `rs2_data[4:0]`}
    - any other funct3 is illegal.
  - funct7 0000001, B = `rs2_data`, by funct3:
    - 000 mul → 001010
    - 001 mulh → 001011
    - 010 mulhsu → 001100
    - 011 mulhu → 001101
    - 100 div → 001000
    - 101 divu → 001001
    - 110 rem → 001110
    - 111 remu → 001111
  - Any other funct7 is illegal.
- OP-IMM (0010011), A = `rs1_data`, B = sign-extended `instr[31:20]`:
  - 000 addi → 000000
  - 010 slti → 000110
  - 011 sltiu → 000111
  - 100 xori → 000011
  - 110 ori → 000010
  - 111 andi → 000001
  - Shifts use B = {27'b0, `instr[24:20]`}:
    - 001 requires funct7 0000000 → 000101
    - 101 with funct7 0000000 → 000100
    - 101 with funct7 0100000 → 010000
    - any other funct7 is illegal.
- LUI (0110111): A = 0, B = {`instr[31:12]`, 12'b0}, ctrl 010111 (pass B).
- Illegal or unknown opcode: `illegal` = 1, ctrl 000000, A = B = 0, `rd` = 0. It is still issued as a normal beat so downstream raises the trap.
- Buffering uses a main register (drives the outputs) and one skid register:
  - States: EMPTY (none valid), ONE (main valid), FULL (main and skid valid).
  - EMPTY + accept → ONE.
  - ONE + accept + no drain → FULL, new entry into skid.
  - ONE + accept + drain → ONE, new entry into main.
  - ONE + drain only → EMPTY.
  - FULL + drain → ONE, skid moves into main. No accept is possible while FULL.
  - Order is strictly FIFO.
- Handshake definitions:
  - accept = `in_valid` & `in_ready`.
  - drain = `out_valid` & `out_ready`.
  - `in_ready` is registered. It is 1 when the next state is not FULL.
- `flush` has top priority. The next state is EMPTY, and any accept or drain in the same cycle is discarded.

## Timing
- On reset, when `rst_n` = 0 at a rising edge, the next state is EMPTY with these output values:
  - `out_valid` = 0, `in_ready` = 1.
  - `alu_a` = `alu_b` = 0, `alu_ctrl` = 0, `rd` = 0, `illegal` = 0.
- Upstream must hold `in_valid` at 0 while `rst_n` = 0.
- Reset mid-operation drops all entries, exactly as `flush` does.
- Latency: a bundle accepted at edge N appears on the outputs after edge N, with `out_valid` = 1 in cycle N+1.
- Throughput: one bundle per cycle while `out_ready` = 1.
- Outputs are stable while `out_valid` & !`out_ready`. Every output is driven from a register; there is no combinational path from input to output.
- Simultaneous accept and drain in ONE keeps occupancy at 1 and does not drop `in_ready`.
- After FULL, `in_ready` returns to 1 in the cycle after the first drain.
- Flush: in the cycle after a flush edge, `out_valid` = 0 and `in_ready` = 1.

## Test plan
- Reset, then one bundle: `instr` 0x00208033 (add x0,x1,x2), rs1 5, rs2 7, `out_ready` 1 → next cycle `out_valid` 1, ctrl 000000, A 5, B 7, `rd` 0, `illegal` 0.
- Encoding sweep:
  - sub 0x40208133 → 010001.
  - sra with rs2 0xFFFFFFE3 → 010000, B 3.
  - srai x1,x1,31 (0x41F0D093) → 010000, B 31.
  - addi imm 0xFFF → B 0xFFFFFFFF.
  - mulhu → 001101.
  - lui 0x12345 → 010111, A 0, B 0x12345000.
- Illegal handling: opcode 1111111, and OP with funct7 0100000/funct3 001 → `illegal` 1, ctrl 0, A = B = 0, `rd` = 0. Both are issued in order.
- Backpressure: stream 4 bundles with `out_ready` 0 → `in_ready` drops to 0 after 2 accepts. Then raise `out_ready` → all 4 emerge in order with no loss or duplication, one per cycle.
- Flush in FULL with `in_valid` 1 → next cycle `out_valid` 0 and `in_ready` 1. The offered bundle and both buffered entries never appear.
- Reset mid-stream (`rst_n` low one cycle while FULL) → outputs return to their reset values and the following stream issues correctly.
